// File: rtl/shreg_load_sequencer.sv
// shreg_load_sequencer
// Arbitrates between two requesters with round-robin priority. It serialises
// the winning parallel word LSB-first onto an external WIDTH-stage right-shift
// register (SERIAL_IN enters the MSB stage). After WIDTH shifts the register
// holds the word, and DONE pulses for one cycle.
//
// Build option: SHREG_SEQ_CLEAR_EN
//   defined   - a CLEAR state pulses CLR for one cycle before each transfer.
//   undefined - no CLEAR state; IDLE goes straight to SHIFT and CLR is tied
//               to 0. Every latency is one cycle shorter. The WIDTH shifts
//               still overwrite every stage, so the loaded word is the same.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; the only state in which READY can be 1
// CLEAR | CLR=1 for one cycle (only with SHREG_SEQ_CLEAR_EN)
// SHIFT | SHIFT=1, SERIAL_IN=data[cnt], WIDTH cycles
// HOLD  | DONE=1 for one cycle; the register keeps the word

module shreg_load_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic [WIDTH-1:0] REQ0_DATA,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [WIDTH-1:0] REQ1_DATA,
    output logic             REQ1_READY,
    output logic             SHIFT,
    output logic             SERIAL_IN,
    output logic             CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic             GRANT_ID
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] data_q;
    logic             grant_q;
    logic             last_grant_q;

    logic             accept;
    logic             winner;
    logic [WIDTH-1:0] winner_data;

    // Round-robin arbitration. Only IDLE accepts a request; on a tie the
    // requester that did not win last time is served.
    always_comb begin
        accept      = 1'b0;
        winner      = 1'b0;
        winner_data = REQ0_DATA;
        if (state_q == S_IDLE) begin
            accept = REQ0_VALID | REQ1_VALID;
            if (REQ0_VALID && REQ1_VALID) begin
                winner = ~last_grant_q;
            end else if (REQ1_VALID) begin
                winner = 1'b1;
            end else begin
                winner = 1'b0;
            end
        end
        if (winner) begin
            winner_data = REQ1_DATA;
        end
        REQ0_READY = accept & ~winner;
        REQ1_READY = accept & winner;
    end

    // State register. The reset is synchronous and drops any transfer that is
    // in progress.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef SHREG_SEQ_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_SHIFT;
`endif
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: latch the winner's word and identity on accept. Step the bit
    // counter while shifting and stop it at the last bit so that it never
    // wraps inside a transfer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q        <= '0;
            data_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            cnt_q        <= '0;
            data_q       <= winner_data;
            grant_q      <= winner;
            last_grant_q <= winner;
        end else if ((state_q == S_SHIFT) && (cnt_q != CNT_LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Moore output decode from registered state, counter and word.
    always_comb begin
        SHIFT     = (state_q == S_SHIFT);
        SERIAL_IN = (state_q == S_SHIFT) ? data_q[cnt_q] : 1'b0;
`ifdef SHREG_SEQ_CLEAR_EN
        CLR       = (state_q == S_CLEAR);
`else
        CLR       = 1'b0;
`endif
        BUSY      = (state_q != S_IDLE);
        DONE      = (state_q == S_HOLD);
        GRANT_ID  = grant_q;
    end

endmodule

// File: tb/tb_shreg_load_sequencer.sv
// Directed bench for shreg_load_sequencer (WIDTH=4) with a 4-stage
// right-shift register model driven by SHIFT/SERIAL_IN/CLR.
// Works in both builds; CLR_CYC tracks whether the CLEAR state exists.

module tb_shreg_load_sequencer;

    localparam int WIDTH = 4;
`ifdef SHREG_SEQ_CLEAR_EN
    localparam int CLR_CYC = 1;
`else
    localparam int CLR_CYC = 0;
`endif

    logic             CLK;
    logic             RST;
    logic             REQ0_VALID;
    logic [WIDTH-1:0] REQ0_DATA;
    logic             REQ0_READY;
    logic             REQ1_VALID;
    logic [WIDTH-1:0] REQ1_DATA;
    logic             REQ1_READY;
    logic             SHIFT;
    logic             SERIAL_IN;
    logic             CLR;
    logic             BUSY;
    logic             DONE;
    logic             GRANT_ID;

    logic [WIDTH-1:0] q_reg = 4'b0110;
    logic [5:0]       obs;

    int checks = 0;
    int errors = 0;

    shreg_load_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_DATA  (REQ0_DATA),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_DATA  (REQ1_DATA),
        .REQ1_READY (REQ1_READY),
        .SHIFT      (SHIFT),
        .SERIAL_IN  (SERIAL_IN),
        .CLR        (CLR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .GRANT_ID   (GRANT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External shift register: serial data enters the MSB, shifts right.
    always @(posedge CLK) begin
        if (CLR) q_reg <= '0;
        else if (SHIFT) q_reg <= {SERIAL_IN, q_reg[WIDTH-1:1]};
    end

    assign obs = {CLR, SHIFT, SERIAL_IN, DONE, BUSY, REQ0_READY | REQ1_READY};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        #1;
    endtask

    // Precondition: IDLE cycle with requester id about to be accepted.
    // Checks every cycle of the transfer and the final register contents.
    task automatic run_transfer(input logic id, input logic [WIDTH-1:0] word,
                                input bit release_req, input string name);
        logic [5:0] expv;
        logic       sh;
        logic       sbit;
        checks++;
        if ({REQ1_READY, REQ0_READY} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s accept_ready got=%b want=%b", name,
                     {REQ1_READY, REQ0_READY}, (id ? 2'b10 : 2'b01));
        end
        tick();
        if (release_req) begin
            if (id) begin
                REQ1_VALID = 1'b0;
                REQ1_DATA  = ~word;
            end else begin
                REQ0_VALID = 1'b0;
                REQ0_DATA  = ~word;
            end
            #1;
        end
        for (int k = 1; k <= CLR_CYC + WIDTH + 1; k++) begin
            sh   = (k >= CLR_CYC + 1) && (k <= CLR_CYC + WIDTH);
            sbit = 1'b0;
            if (sh) sbit = word[k - CLR_CYC - 1];
            expv = {(CLR_CYC == 1) && (k == 1), sh, sbit,
                    (k == CLR_CYC + WIDTH + 1), 1'b1, 1'b0};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL %s cycle%0d {clr,shift,sin,done,busy,ready} got=%b want=%b",
                         name, k, obs, expv);
            end
            tick();
        end
        checks++;
        if ({BUSY, DONE, GRANT_ID, q_reg} !== {1'b0, 1'b0, id, word}) begin
            errors++;
            $display("FAIL %s end {busy,done,grant,q} got=%b want=%b", name,
                     {BUSY, DONE, GRANT_ID, q_reg}, {1'b0, 1'b0, id, word});
        end
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] q_start;
        RST = 1'b0;
        tick();
        tick();
        checks++;
        if ({obs, GRANT_ID} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", {obs, GRANT_ID}, 7'b0);
        end
        RST = 1'b1;
        q_start = q_reg;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({obs, GRANT_ID} !== 7'b0) begin
                errors++;
                $display("FAIL idle_outputs cycle%0d got=%b want=%b", i, {obs, GRANT_ID}, 7'b0);
            end
        end
        checks++;
        if (q_reg !== q_start) begin
            errors++;
            $display("FAIL idle_reg_hold got=%b want=%b", q_reg, q_start);
        end
    endtask

    task automatic test_single();
        REQ0_DATA  = 4'b1011;
        REQ0_VALID = 1'b1;
        #1;
        run_transfer(1'b0, 4'b1011, 1'b1, "single_req0");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        REQ0_DATA  = 4'h5;
        REQ1_DATA  = 4'hA;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        #1;
        run_transfer(1'b0, 4'h5, 1'b0, "b2b_1");
        run_transfer(1'b1, 4'hA, 1'b0, "b2b_2");
        run_transfer(1'b0, 4'h5, 1'b0, "b2b_3");
        run_transfer(1'b1, 4'hA, 1'b0, "b2b_4");
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        #1;
    endtask

    task automatic test_late_req();
        int k;
        REQ0_DATA  = 4'b0011;
        REQ0_VALID = 1'b1;
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin
            errors++;
            $display("FAIL late_ready0 got=%b want=1", REQ0_READY);
        end
        tick();
        REQ0_VALID = 1'b0;
        tick();
        tick();
        k = 3;
        REQ1_DATA  = 4'h6;
        REQ1_VALID = 1'b1;
        #1;
        while (!REQ1_READY && k < 25) begin
            tick();
            k++;
        end
        checks++;
        if (k != CLR_CYC + WIDTH + 2) begin
            errors++;
            $display("FAIL late_req1_accept_offset got=%0d want=%0d", k, CLR_CYC + WIDTH + 2);
        end
        checks++;
        if (q_reg !== 4'b0011) begin
            errors++;
            $display("FAIL late_req0_word got=%b want=%b", q_reg, 4'b0011);
        end
        if (REQ1_READY) run_transfer(1'b1, 4'h6, 1'b1, "late_req1");
        else REQ1_VALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        REQ0_DATA  = 4'b1001;
        REQ0_VALID = 1'b1;
        #1;
        tick();
        REQ0_VALID = 1'b0;
        for (int i = 0; i < CLR_CYC + 1; i++) tick();
        checks++;
        if (SHIFT !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_shift got=%b want=1", SHIFT);
        end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        checks++;
        if ({obs, GRANT_ID} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b want=%b", {obs, GRANT_ID}, 7'b0);
        end
        for (int i = 0; i < WIDTH + 3; i++) begin
            tick();
            checks++;
            if ({DONE, BUSY} !== 2'b00) begin
                errors++;
                $display("FAIL midreset_quiet cycle%0d {done,busy} got=%b want=00", i, {DONE, BUSY});
            end
        end
        REQ1_DATA  = 4'hC;
        REQ1_VALID = 1'b1;
        #1;
        run_transfer(1'b1, 4'hC, 1'b1, "after_reset");
    endtask

    task automatic test_drop_valid();
        REQ0_DATA  = 4'hF;
        REQ0_VALID = 1'b1;
        #1;
        checks++;
        if (REQ0_READY !== 1'b1) begin
            errors++;
            $display("FAIL drop_ready_seen got=%b want=1", REQ0_READY);
        end
        REQ0_VALID = 1'b0;
        #1;
        checks++;
        if (REQ0_READY !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready_gone got=%b want=0", REQ0_READY);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({obs, GRANT_ID} !== 7'b0000001) begin
                errors++;
                $display("FAIL drop_no_transfer cycle%0d got=%b want=%b", i, {obs, GRANT_ID}, 7'b0000001);
            end
        end
    endtask

    initial begin
        RST        = 1'b0;
        REQ0_VALID = 1'b0;
        REQ0_DATA  = '0;
        REQ1_VALID = 1'b0;
        REQ1_DATA  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_late_req();
        test_reset_mid();
        test_drop_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
